// File: rtl/som_pkg.sv
// Shared types and constants for the SOM epoch scheduler and its neighbourhood mask generator.
package som_pkg;

  localparam int VEP_DIM   = 8;
  localparam int VEP_NUM   = 64;
  localparam int PIX_CNT_W = 13;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_PASS,
    S_TRAIN,
    S_EPOCH_END,
    S_WRITE_START,
    S_WRITE,
    S_DONE
  } state_t;

  // Zero-extended to 4 bits so the distance never wraps at the array edges.
  function automatic logic [3:0] abs_diff(input logic [2:0] a, input logic [2:0] b);
    logic [3:0] ea;
    logic [3:0] eb;
    ea = {1'b0, a};
    eb = {1'b0, b};
    return (ea >= eb) ? (ea - eb) : (eb - ea);
  endfunction

endpackage

// File: rtl/som_nbr_mask.sv
// Registered Chebyshev-neighbourhood mask around the winning VEP, one cycle after win_valid.
module som_nbr_mask
  import som_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               win_valid,
  input  logic [2:0]         winner_x,
  input  logic [2:0]         winner_y,
  input  logic [2:0]         radius,
  output logic [VEP_NUM-1:0] nbr_mask,
  output logic               nbr_valid
);

  logic [VEP_NUM-1:0] mask_next;

  always_comb begin
    mask_next = '0;
    for (int y = 0; y < VEP_DIM; y++) begin
      for (int x = 0; x < VEP_DIM; x++) begin
        mask_next[y*VEP_DIM+x] = (abs_diff(3'(x), winner_x) <= {1'b0, radius}) &&
                                 (abs_diff(3'(y), winner_y) <= {1'b0, radius});
      end
    end
  end

  // The mask is only reloaded on a new winner so it holds between updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nbr_valid <= 1'b0;
      nbr_mask  <= '0;
    end else begin
      nbr_valid <= win_valid;
      if (win_valid) nbr_mask <= mask_next;
    end
  end

endmodule

// File: rtl/som_train_sched.sv
// Epoch scheduler: sequences training passes and the final write pass, and decays
// learning-rate shift and neighbourhood radius once per epoch.
module som_train_sched
  import som_pkg::*;
#(
  parameter int PIX_CNT       = 4096,
  parameter int RADIUS_INIT   = 3,
  parameter int LR_SHIFT_INIT = 1,
  parameter int LR_SHIFT_MAX  = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         cfg_epochs,
  output logic               pass_start,
  output logic               pass_write,
  input  logic               pix_valid,
  input  logic               pass_done,
  input  logic               win_valid,
  input  logic [2:0]         winner_x,
  input  logic [2:0]         winner_y,
  output logic [VEP_NUM-1:0] nbr_mask,
  output logic               nbr_valid,
  output logic               update_en,
  output logic [2:0]         lr_shift,
  output logic [2:0]         radius,
  output logic [3:0]         epoch,
  output logic               busy,
  output logic               done,
  output logic               err_pixcnt
);

  localparam logic [PIX_CNT_W-1:0] PIX_TARGET = PIX_CNT_W'(PIX_CNT);

  state_t               state;
  logic [3:0]           cfg_lat;
  logic [PIX_CNT_W-1:0] pix_cnt;
  logic [PIX_CNT_W-1:0] pix_cnt_next;
  logic [3:0]           epoch_inc;

  // Saturating count that already includes a pix_valid arriving with pass_done.
  always_comb begin
    pix_cnt_next = pix_cnt;
    if (pix_valid && (pix_cnt != '1)) pix_cnt_next = pix_cnt + 1'b1;
    epoch_inc = epoch + 4'd1;
  end

  // Outputs are set on the transition into a state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cfg_lat    <= '0;
      pix_cnt    <= '0;
      epoch      <= '0;
      lr_shift   <= 3'(LR_SHIFT_INIT);
      radius     <= 3'(RADIUS_INIT);
      pass_start <= 1'b0;
      pass_write <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_pixcnt <= 1'b0;
    end else begin
      pass_start <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            cfg_lat    <= cfg_epochs;
            err_pixcnt <= 1'b0;
            epoch      <= '0;
            lr_shift   <= 3'(LR_SHIFT_INIT);
            radius     <= 3'(RADIUS_INIT);
            done       <= 1'b0;
            busy       <= 1'b1;
            pix_cnt    <= '0;
            pass_start <= 1'b1;
            if (cfg_epochs == 4'd0) begin
              state      <= S_WRITE_START;
              pass_write <= 1'b1;
            end else begin
              state      <= S_START_PASS;
              pass_write <= 1'b0;
            end
          end
        end
        S_START_PASS: state <= S_TRAIN;
        S_TRAIN: begin
          pix_cnt <= pix_cnt_next;
          if (pass_done) begin
            if (pix_cnt_next != PIX_TARGET) err_pixcnt <= 1'b1;
            state <= S_EPOCH_END;
          end
        end
        S_EPOCH_END: begin
          epoch      <= epoch_inc;
          pix_cnt    <= '0;
          pass_start <= 1'b1;
          if (epoch_inc == cfg_lat) begin
            state      <= S_WRITE_START;
            pass_write <= 1'b1;
          end else begin
            state      <= S_START_PASS;
            pass_write <= 1'b0;
            if (lr_shift < 3'(LR_SHIFT_MAX)) lr_shift <= lr_shift + 3'd1;
            if (radius != 3'd0) radius <= radius - 3'd1;
          end
        end
        S_WRITE_START: state <= S_WRITE;
        S_WRITE: begin
          pix_cnt <= pix_cnt_next;
          if (pass_done) begin
            if (pix_cnt_next != PIX_TARGET) err_pixcnt <= 1'b1;
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) update_en <= 1'b0;
    else     update_en <= win_valid && (state == S_TRAIN);
  end

  som_nbr_mask u_nbr_mask (
    .clk       (clk),
    .rst       (rst),
    .win_valid (win_valid),
    .winner_x  (winner_x),
    .winner_y  (winner_y),
    .radius    (radius),
    .nbr_mask  (nbr_mask),
    .nbr_valid (nbr_valid)
  );

endmodule

// File: doc/som_train_sched.md
Name: som_train_sched

Overview:
- Epoch-level scheduler for the SOM processing system. It sits above the pixel-sequencing controller and the 8x8 VEP array.
- Runs a configurable number of training passes over the 64x64 input picture, then one final write pass to the output picture.
- Steps the learning-rate shift and the neighbourhood radius down each epoch.
- Turns each winner coordinate into a registered 64-bit neighbourhood update mask for the VEP array.

Parameters:
- PIX_CNT, 4096: pixels visited per pass.
- RADIUS_INIT, 3: neighbourhood radius (Chebyshev distance) in epoch 0.
- LR_SHIFT_INIT, 1: learning-rate right-shift in epoch 0.
- LR_SHIFT_MAX, 6: saturation value of the learning-rate shift.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begins a run; ignored unless state is IDLE or DONE
- cfg_epochs  in  4  number of training passes (0 = no training, write pass only); sampled on an accepted start
- pass_start  out  1  one-cycle pulse; tells the pixel sequencer to begin a pass
- pass_write  out  1  1 = current pass is the output-write pass; 0 = training pass
- pix_valid  in  1  one pulse per pixel visited by the sequencer
- pass_done  in  1  one-cycle pulse at the end of the sequencer's pass
- win_valid  in  1  winner coordinate valid this cycle
- winner_x  in  3  winner VEP column
- winner_y  in  3  winner VEP row
- nbr_mask  out  64  bit y*8+x set when that VEP is inside the neighbourhood
- nbr_valid  out  1  nbr_mask valid, one cycle after win_valid
- update_en  out  1  weight-update strobe to the VEP array
- lr_shift  out  3  current learning-rate shift
- radius  out  3  current neighbourhood radius
- epoch  out  4  index of the current training epoch
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high in DONE
- err_pixcnt  out  1  sticky flag: a pass ended with a pixel count other than PIX_CNT

Behaviour:
- Reset values:
  - state = IDLE
  - pass_start, pass_write, nbr_valid, update_en, busy, done, err_pixcnt = 0
  - nbr_mask = 0, epoch = 0, pixel counter = 0
  - lr_shift = LR_SHIFT_INIT, radius = RADIUS_INIT
- Reset asserted mid-run returns everything to these values at once. No pass handshake is completed.
- States: IDLE, START_PASS, TRAIN, EPOCH_END, WRITE_START, WRITE, DONE.
- IDLE or DONE with start = 1:
  - Latch cfg_epochs, clear err_pixcnt.
  - Load epoch = 0, lr_shift = LR_SHIFT_INIT, radius = RADIUS_INIT.
  - done is cleared in the next cycle.
  - Go to WRITE_START if the latched value is 0, otherwise to START_PASS.
- START_PASS: pass_start = 1 for exactly this cycle, pass_write = 0, pixel counter cleared. Next state TRAIN.
- TRAIN:
  - Each pix_valid increments a 13-bit pixel counter; the counter saturates at 8191.
  - On pass_done: if the count, including a pix_valid in the same cycle, is not PIX_CNT, set err_pixcnt. Go to EPOCH_END.
- EPOCH_END: epoch increments.
  - If the new epoch equals the latched cfg_epochs, go to WRITE_START and leave lr_shift and radius unchanged.
  - Otherwise lr_shift = min(lr_shift+1, LR_SHIFT_MAX) and radius = max(radius-1, 0), then go to START_PASS.
- WRITE_START: pass_start = 1 for one cycle, pass_write = 1, pixel counter cleared. Next state WRITE.
- WRITE: count pix_valid the same way as TRAIN. On pass_done, do the count check, then go to DONE.
- pass_write stays 1 through WRITE and DONE. It returns to 0 at the next START_PASS, or at reset.
- DONE: done = 1 and held until a new start is accepted.
- Neighbourhood mask, latency 1:
  - On win_valid, for every VEP (x,y): mask bit = (|x-winner_x| <= radius) AND (|y-winner_y| <= radius).
  - Use 4-bit unsigned difference arithmetic, with no wrap at the array edges.
  - nbr_valid = win_valid delayed one cycle. nbr_mask holds its last value when nbr_valid = 0.
  - radius 0 gives a one-hot mask; radius 7 gives all ones.
- update_en = registered (win_valid AND state == TRAIN). It aligns with nbr_valid.
- update_en is never set during the write pass.
- pass_done in any state other than TRAIN or WRITE is ignored. pix_valid outside TRAIN or WRITE is ignored.

Decomposition:
- Shared package som_pkg:
  - State encoding.
  - Constants VEP_DIM = 8, VEP_NUM = 64, PIX_CNT_W = 13.
- One sub-module, som_nbr_mask: registered winner/radius to 64-bit mask generator containing the 64 comparators and the valid pipeline.
- The FSM, counters and schedule registers stay in the top.

Test Plan:
- cfg_epochs = 2, the sequencer model returns 4096 pix_valid and then pass_done each pass -> exactly 3 pass_start pulses, the third with pass_write = 1.
  - During epoch 1: lr_shift = 2, radius = 2.
  - At the end: done = 1, err_pixcnt = 0.
- cfg_epochs = 0 -> one pass_start with pass_write = 1, update_en never asserted, done after pass_done.
- cfg_epochs = 8 with default parameters:
  - lr_shift sequence is 1,2,3,4,5,6,6,6.
  - radius sequence is 3,2,1,0,0,0,0,0.
- Mask checks:
  - radius 1, winner (0,0) -> nbr_mask = 0x0000_0000_0000_0303, one cycle after win_valid.
  - radius 0, winner (7,7) -> bit 63 only.
- Pass ended after 4095 pixels -> err_pixcnt = 1 and sticky through DONE. A new start clears it.
- Reset pulse mid-TRAIN -> all outputs return to reset values. A start issued during the run (busy = 1) is ignored.
